// File: rtl/mac_array_feeder_l4.sv
// rtl/mac_array_feeder_l4.sv - pixel x chunk sequencer feeding the layer-4 MAC tree array
// Issues buffer addresses, registers read data to the array and flags final pixel results.
module mac_array_feeder_l4 #(
  parameter int M      = 8,
  parameter int CHUNKS = 16,
  parameter int PIXELS = 16,
  parameter int AW     = 10,
  parameter int TL     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     act_addr,
  input  logic [63:0]       act_rdata,
  output logic [AW-1:0]     wt_addr,
  input  logic [M*64-1:0]   wt_rdata,
  output logic [63:0]       data_in,
  output logic [M*64-1:0]   weight,
  output logic              load,
  output logic              res_valid,
  output logic [AW-1:0]     res_pix
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam int CW = $clog2(TL + 2) + 1;
  localparam logic [AW-1:0] LAST_CHUNK = AW'(CHUNKS - 1);
  localparam logic [AW-1:0] LAST_PIX   = AW'(PIXELS - 1);
  localparam logic [CW-1:0] DRAIN_END  = CW'(TL + 1);

  state_t          state;
  logic [AW-1:0]   pix;
  logic [CW-1:0]   cnt;
  logic            v1, first1, last1;
  logic [AW-1:0]   pix1;
  logic            v2, last2;
  logic [AW-1:0]   pix2;
  logic [TL-1:0]   dl_v;
  logic [AW-1:0]   dl_pix [TL];

  // wt_addr doubles as the chunk counter and act_addr as the linear pix*CHUNKS+chunk index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      act_addr <= '0;
      wt_addr  <= '0;
      pix      <= '0;
      cnt      <= '0;
      v1       <= 1'b0;
      first1   <= 1'b0;
      last1    <= 1'b0;
      pix1     <= '0;
    end else begin
      done <= 1'b0;
      v1   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            act_addr <= '0;
            wt_addr  <= '0;
            pix      <= '0;
            cnt      <= '0;
          end else if (done) begin
            busy <= 1'b0;
          end
        end
        FETCH: begin
          v1     <= 1'b1;
          first1 <= (wt_addr == '0);
          last1  <= (wt_addr == LAST_CHUNK);
          pix1   <= pix;
          if (wt_addr == LAST_CHUNK && pix == LAST_PIX) begin
            state <= DRAIN;
          end else begin
            act_addr <= act_addr + AW'(1);
            if (wt_addr == LAST_CHUNK) begin
              wt_addr <= '0;
              pix     <= pix + AW'(1);
            end else begin
              wt_addr <= wt_addr + AW'(1);
            end
          end
        end
        DRAIN: begin
          // busy stays high through the done cycle; it drops on the following edge
          if (cnt == DRAIN_END) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2      <= 1'b0;
      last2   <= 1'b0;
      pix2    <= '0;
      data_in <= '0;
      weight  <= '0;
      load    <= 1'b0;
      dl_v    <= '0;
      for (int i = 0; i < TL; i++) dl_pix[i] <= '0;
    end else begin
      v2      <= v1;
      last2   <= last1;
      pix2    <= pix1;
      data_in <= v1 ? act_rdata : '0;
      weight  <= v1 ? wt_rdata : '0;
      load    <= v1 & first1;
      dl_v[0]   <= v2 & last2;
      dl_pix[0] <= pix2;
      for (int i = 1; i < TL; i++) begin
        dl_v[i]   <= dl_v[i-1];
        dl_pix[i] <= dl_pix[i-1];
      end
    end
  end

  assign res_valid = dl_v[TL-1];
  assign res_pix   = dl_pix[TL-1];

endmodule

// File: tb/tb_mac_array_feeder_l4.sv
// tb/tb_mac_array_feeder_l4.sv - directed table-driven bench for mac_array_feeder_l4
module tb_mac_array_feeder_l4;
  localparam int M = 2, CHUNKS = 4, PIXELS = 2, AW = 10, TL = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            busy, done, load, res_valid;
  logic [AW-1:0]   act_addr, wt_addr, res_pix;
  logic [63:0]     act_rdata = '0;
  logic [M*64-1:0] wt_rdata = '0;
  logic [63:0]     data_in;
  logic [M*64-1:0] weight;

  int total = 0;
  int bad = 0;

  mac_array_feeder_l4 #(.M(M), .CHUNKS(CHUNKS), .PIXELS(PIXELS), .AW(AW), .TL(TL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .act_addr(act_addr), .act_rdata(act_rdata), .wt_addr(wt_addr), .wt_rdata(wt_rdata),
    .data_in(data_in), .weight(weight), .load(load),
    .res_valid(res_valid), .res_pix(res_pix)
  );

  always #5 clk = ~clk;

  // buffers: act[a] = a in every lane, weight for chunk c = 0x100+c in every lane
  always @(posedge clk) begin
    act_rdata <= {4{16'(act_addr)}};
    wt_rdata  <= {M*4{16'h0100 + 16'(wt_addr)}};
  end

  typedef struct {
    int aa;  // expected act_addr, -1 = unchecked
    int din; // expected lane value, -1 = zero
    int wc;  // expected weight chunk, -1 = zero
    int ld, rv, rp, dn, bz;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, 128'(busy), 0);
    chk({pfx, "_done"}, 128'(done), 0);
    chk({pfx, "_load"}, 128'(load), 0);
    chk({pfx, "_res_valid"}, 128'(res_valid), 0);
    chk({pfx, "_res_pix"}, 128'(res_pix), 0);
    chk({pfx, "_data_in"}, 128'(data_in), 0);
    chk({pfx, "_weight"}, 128'(weight), 0);
    chk({pfx, "_act_addr"}, 128'(act_addr), 0);
    chk({pfx, "_wt_addr"}, 128'(wt_addr), 0);
  endtask

  task automatic chk_vec(input string pfx, input int k);
    vec_t v;
    logic [63:0] dexp;
    logic [M*64-1:0] wexp;
    v = tbl[k];
    dexp = (v.din < 0) ? 64'd0 : {4{16'(v.din)}};
    wexp = (v.wc < 0) ? '0 : {M*4{16'h0100 + 16'(v.wc)}};
    if (v.aa >= 0) chk($sformatf("%s_e%0d_act_addr", pfx, k), 128'(act_addr), 128'(v.aa));
    chk($sformatf("%s_e%0d_data_in", pfx, k), 128'(data_in), 128'(dexp));
    chk($sformatf("%s_e%0d_weight", pfx, k), 128'(weight), 128'(wexp));
    chk($sformatf("%s_e%0d_load", pfx, k), 128'(load), 128'(v.ld));
    chk($sformatf("%s_e%0d_res_valid", pfx, k), 128'(res_valid), 128'(v.rv));
    if (v.rv != 0) chk($sformatf("%s_e%0d_res_pix", pfx, k), 128'(res_pix), 128'(v.rp));
    chk($sformatf("%s_e%0d_done", pfx, k), 128'(done), 128'(v.dn));
    chk($sformatf("%s_e%0d_busy", pfx, k), 128'(busy), 128'(v.bz));
  endtask

  // called #1 after an edge; start is sampled on the next edge (E0)
  task automatic run_basic(input string pfx, input int pulse_at);
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      start = (k + 1 == pulse_at);
      chk_vec(pfx, k);
    end
  endtask

  initial begin
    //          aa  din  wc ld rv rp dn bz
    tbl[0]  = '{ 0,  -1, -1, 0, 0, 0, 0, 1};
    tbl[1]  = '{ 1,  -1, -1, 0, 0, 0, 0, 1};
    tbl[2]  = '{ 2,   0,  0, 1, 0, 0, 0, 1};
    tbl[3]  = '{ 3,   1,  1, 0, 0, 0, 0, 1};
    tbl[4]  = '{ 4,   2,  2, 0, 0, 0, 0, 1};
    tbl[5]  = '{ 5,   3,  3, 0, 0, 0, 0, 1};
    tbl[6]  = '{ 6,   4,  0, 1, 0, 0, 0, 1};
    tbl[7]  = '{ 7,   5,  1, 0, 0, 0, 0, 1};
    tbl[8]  = '{-1,   6,  2, 0, 1, 0, 0, 1};
    tbl[9]  = '{-1,   7,  3, 0, 0, 0, 0, 1};
    tbl[10] = '{-1,  -1, -1, 0, 0, 0, 0, 1};
    tbl[11] = '{-1,  -1, -1, 0, 0, 0, 0, 1};
    tbl[12] = '{-1,  -1, -1, 0, 1, 1, 0, 1};
    tbl[13] = '{-1,  -1, -1, 0, 0, 0, 1, 1};
    for (int k = 14; k < 20; k++) tbl[k] = '{-1, -1, -1, 0, 0, 0, 0, 0};

    // reset values while held in reset
    #12;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_basic("basic", -1);
    run_basic("busy_start", 5);

    // mid-run reset, asserted between edges
    begin
      logic seen;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
        @(posedge clk);
        #1;
      end
      #2;
      rst = 1'b1;
      #1;
      chk_zero("midrst");
      seen = 1'b0;
      for (int k = 8; k < 20; k++) begin
        @(posedge clk);
        #1;
        if (k == 9) rst = 1'b0;
        seen = seen | res_valid | done | busy;
      end
      chk("abort_quiet", 128'(seen), 0);
      run_basic("rerun", -1);
    end

    // back-to-back runs with start held high
    start = 1'b1;
    for (int k = 0; k < 28; k++) begin
      @(posedge clk);
      #1;
      if (k == 27) start = 1'b0;
      chk($sformatf("b2b_e%0d_done", k), 128'(done), 128'(k == 13 || k == 27));
      if (k == 14) chk("b2b_restart_addr", 128'(act_addr), 0);
      if (k == 15) chk("b2b_addr1", 128'(act_addr), 1);
      if (k == 16) chk("b2b_load", 128'(load), 1);
      if (k == 16) chk("b2b_data0", 128'(data_in), 0);
      if (k == 17) chk("b2b_data1", 128'(data_in), 128'({4{16'd1}}));
      if (k == 22) chk("b2b_res0", 128'(res_valid), 1);
      if (k == 26) chk("b2b_res_pix1", 128'(res_pix), 1);
      if (k == 14 || k == 20) chk($sformatf("b2b_e%0d_busy", k), 128'(busy), 1);
    end
    @(posedge clk);
    #1;
    chk("b2b_end_busy", 128'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_array_feeder_l4.md
# mac_array_feeder_l4

Sequencer driving the layer-4 multiply-accumulate tree array, a bank of M 16-bit filter lanes that share one 4-element input vector per cycle. It walks a pixel × channel-chunk schedule, issues read addresses to the activation and weight buffers, and presents each 4-element chunk together with its weights. It pulses `load` at the start of every pixel's accumulation. It also tells the downstream result writer exactly when each pixel's M filter outputs are final.

## Interface
- `M`, 8, number of filter lanes (weight bus is M×4×16 bits)
- `CHUNKS`, 16, 4-channel chunks per pixel (≥2)
- `PIXELS`, 16, pixels per run (≥1)
- `AW`, 10, address width; PIXELS×CHUNKS ≤ 2^AW
- `TL`, 3, cycles from last chunk on `data_in` to final `out_filter` of the tree array (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: begin a run; sampled only in IDLE
- `busy` out 1: run in progress
- `done` out 1: one-cycle pulse at end of run
- `act_addr` out AW: activation buffer address = pix×CHUNKS+chunk
- `act_rdata` in 64: 4×16 activations, valid one cycle after `act_addr` (sync read)
- `wt_addr` out AW: weight buffer address = chunk
- `wt_rdata` in M×64: weights for all lanes, valid one cycle after `wt_addr`
- `data_in` out 64: registered chunk to the tree array
- `weight` out M×64: registered weights to the tree array
- `load` out 1: high with the first chunk of every pixel
- `res_valid` out 1: one-cycle pulse; tree outputs for `res_pix` are final
- `res_pix` out AW: pixel index qualified by `res_valid`

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE: when `start`=1, go to FETCH with pix=0, chunk=0.
- FETCH issues one address pair per cycle. chunk increments each cycle. When chunk reaches CHUNKS−1 it wraps to 0 and pix increments.
- FETCH ends when the address for (PIXELS−1, CHUNKS−1) has been issued; the next state is DRAIN.
- Stage-1 pipeline registers follow each issued address: v1, first1 (chunk==0), last1 (chunk==CHUNKS−1), pix1.
- Stage 2 captures the read data.
  - If v1=1: `data_in`←`act_rdata`, `weight`←`wt_rdata`, `load`←first1.
  - If v1=0: `data_in`←0, `weight`←0, `load`←0. Zero-gating keeps the array's accumulators unchanged.
- `load` semantics, shared contract with the tree array: the tree discards its accumulation and restarts from bias plus the current products.
- Result delay line, TL stages deep, carries (last2 & v2, pix2). Its output drives `res_valid`/`res_pix`. Pixel groups pipeline back-to-back with no bubbles.
- DRAIN counts until the stage-2 register and the delay line are empty. It then asserts `done` for one cycle and returns to IDLE.
- `busy` = (state ≠ IDLE). It falls in the cycle after `done`.
- `start` is ignored while `busy`=1. `start` on the same edge that `done` is asserted is also ignored; it must be re-asserted in IDLE.
- Address arithmetic is unsigned AW-bit with no wrap. The parameter constraint guarantees no overflow.
- `rst` asserted at any time, including mid-run, forces IDLE and clears all pipeline and delay-line valids immediately. The aborted run produces no `done` and no further `res_valid`.

## Timing
- Values after reset: `busy`=0, `done`=0, `load`=0, `res_valid`=0, `data_in`=0, `weight`=0, `act_addr`=0, `wt_addr`=0, `res_pix`=0.
- Edge numbering: `start` is sampled at edge E0; N = PIXELS×CHUNKS.
- Addresses for (p,k) appear after edge E0+p×CHUNKS+k.
- The chunk for (p,k) appears on `data_in`/`weight` after edge E0+2+p×CHUNKS+k.
- `load`=1 after edge E0+2+p×CHUNKS, for each p.
- `res_valid` for pixel p is high after edge E0+1+(p+1)×CHUNKS+TL, for exactly one cycle.
- `done` is high after edge E0+N+TL+2, for one cycle.
- `busy` is high from after E0 through the `done` cycle.
- Throughput: one chunk per cycle, 100% utilisation during FETCH.

## Test plan
- Reset values:
  - Stimulus: assert `rst` asynchronously between edges.
  - Required: all outputs are 0 immediately, before the next edge, and state is IDLE.
- Basic run, CHUNKS=4, PIXELS=2, TL=3, buffers preloaded with act[a]=a replicated in all 4 lanes:
  - Stimulus: `start` at E0.
  - Required: `data_in` lanes = 0..7 after edges 2..9; `load` high after edges 2 and 6 only; `res_valid` with `res_pix`=0 after edge 8 and `res_pix`=1 after edge 12; `done` after edge 13; `busy` low after edge 14.
- Zero-gating:
  - Stimulus: check the cycles after edges 10–13 of the basic run.
  - Required: `data_in`=0, `weight`=0 and `load`=0 in those cycles.
- Start while busy:
  - Stimulus: pulse `start` at edge 5 during the basic run.
  - Required: the schedule is unchanged and exactly one `done` occurs.
- Mid-run reset:
  - Stimulus: assert `rst` after edge 7, release it, then `start` at edge 20.
  - Required: no `res_valid` or `done` from the aborted run; the new run replays the basic timing offset by 20.
- Back-to-back runs:
  - Stimulus: `start` held high continuously.
  - Required: second run's E0 is the edge after `busy` falls (edge 14); addresses restart at 0; `done` pulses at edges 13 and 27.
